boot_loader: RTL
================

Name: boot_loader

Overview:
- Fills instruction memory from a byte-serial link before the single-cycle processor runs.
- Holds the processor in reset until the image is loaded and its checksum verified.
- Sits directly upstream of the instruction memory write port and the processor's run/reset gate.
- Image format is big-endian, matching MIPS byte order:
  - a 32-bit word count N;
  - N instruction words;
  - a 32-bit additive checksum.

Parameters:
ADDR_WIDTH, 10, width of the word index into instruction memory; capacity MAX_WORDS = 2**ADDR_WIDTH.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset_n  input  1  asynchronous active-low reset.
byte_data  input  8  incoming image byte.
byte_valid  input  1  byte_data is valid this cycle.
byte_ready  output  1  loader can accept a byte this cycle.
reload  input  1  single-cycle pulse; restarts loading from DONE or ERR.
im_we  output  1  instruction memory write strobe, one cycle per word.
im_addr  output  ADDR_WIDTH  word index; byte address = im_addr<<2.
im_wdata  output  32  instruction word to write.
cpu_run  output  1  high only in DONE; gates the processor clock-enable/reset.
load_err  output  1  high only in ERR.
words_loaded  output  ADDR_WIDTH+1  count of words written so far.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state = HDR; byte counter = 0; word index = 0; sum = 0.
  - All outputs 0, except byte_ready = 1 once reset deasserts.
  - Reset mid-load abandons the image. Memory contents already written are not cleared.
- Handshake:
  - A byte is accepted on a rising edge where byte_valid && byte_ready.
  - byte_ready = 1 in HDR, LOAD and SUM; 0 in DONE and ERR.
  - byte_data must be held while byte_valid is high and byte_ready is low.
- Word assembly:
  - A 2-bit byte counter; the first accepted byte of each word goes to [31:24], the last to [7:0].
  - The counter wraps 3->0 on the 4th byte; that byte completes the word.
- HDR:
  - On word completion, N is latched.
  - N == 0 -> SUM.
  - N > MAX_WORDS -> ERR, with load_err = 1 on the next cycle.
  - Otherwise -> LOAD.
- LOAD:
  - On each word completion, in the next cycle: im_we = 1 for exactly one cycle, im_addr = current word index, im_wdata = word.
  - In that same cycle, word index and words_loaded increment, and sum = sum + word (mod 2^32, carry discarded).
  - When the Nth word completes -> SUM. Its im_we pulse still occurs in the cycle after completion.
  - Byte acceptance continues without stall: a byte may be accepted in the same cycle as an im_we pulse.
  - Minimum spacing between words is 4 cycles, so there are never overlapping writes.
- SUM:
  - On word completion, compare the word with sum.
  - Equal -> DONE, cpu_run = 1 from the next cycle.
  - Not equal -> ERR, load_err = 1.
- DONE / ERR:
  - Sticky; byte_valid is ignored.
  - reload = 1 -> HDR: clears cpu_run, load_err, sum, word index, words_loaded and byte counter.
  - reload in HDR, LOAD or SUM is ignored.
- Idle gaps: byte_valid may drop for any number of cycles; partial word state is retained.
- im_addr and im_wdata hold their last value when im_we = 0.
- im_we is never asserted outside the cycle following a LOAD-word completion. Header and checksum words are never written to memory.

Test Plan:
- Reset, then stream N=2 (00 00 00 02), words 0x20080005 and 0x20090007, checksum 0x4011000C, with byte_valid always high -> im_we pulses at addr 0 data 0x20080005 and addr 1 data 0x20090007; cpu_run = 1; words_loaded = 2; byte_ready = 0.
- Same image but checksum 0x4011000D -> load_err = 1, cpu_run stays 0; both words still written.
- Header 0x00000401 with ADDR_WIDTH=10 -> load_err = 1 one cycle after the 4th header byte; no im_we pulses.
- N=0, checksum 0x00000000 -> cpu_run = 1, no writes. With checksum 0x00000001 instead -> load_err = 1.
- Random byte_valid gaps of 0-5 cycles during the first image -> identical writes and result as the gap-free run.
- Pull reset_n low after 6 bytes of the first image, release, resend the full image -> correct load. Then pulse reload while cpu_run = 1 -> cpu_run = 0, byte_ready = 1, words_loaded = 0.

Source files
------------

// File: rtl/boot_loader_if.sv
// Byte link, instruction-memory write port and run/status signals of the boot loader.
// Byte link: a byte moves on a rising edge where byte_valid && byte_ready; byte_data is held while valid waits on ready.
interface boot_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic [7:0]            byte_data;
  logic                  byte_valid;
  logic                  byte_ready;
  logic                  reload;
  logic                  im_we;
  logic [ADDR_WIDTH-1:0] im_addr;
  logic [31:0]           im_wdata;
  logic                  cpu_run;
  logic                  load_err;
  logic [ADDR_WIDTH:0]   words_loaded;
  logic [2:0]            dbg_state;

  modport master (
    output byte_data, byte_valid, reload,
    input  byte_ready, im_we, im_addr, im_wdata, cpu_run, load_err, words_loaded, dbg_state
  );

  modport slave (
    input  byte_data, byte_valid, reload,
    output byte_ready, im_we, im_addr, im_wdata, cpu_run, load_err, words_loaded, dbg_state
  );
endinterface

// File: rtl/boot_loader.sv
// Loads a big-endian image (count, words, additive checksum) into instruction memory
// and releases the processor only after the checksum matches.
module boot_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic          clk,
  input  logic          reset_n,
  boot_loader_if.slave  bl
);

  localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_HDR  = 3'd0,
    S_LOAD = 3'd1,
    S_SUM  = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [23:0]           shift_q, shift_d;
  logic [ADDR_WIDTH:0]   n_q, n_d;
  logic [ADDR_WIDTH:0]   loaded_q, loaded_d;
  logic [31:0]           sum_q, sum_d;
  logic                  im_we_q, im_we_d;
  logic [ADDR_WIDTH-1:0] im_addr_q, im_addr_d;
  logic [31:0]           im_wdata_q, im_wdata_d;

  logic                  ready_int;
  logic                  accept;
  logic                  word_done;
  logic [31:0]           word;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_HDR;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      n_q        <= '0;
      loaded_q   <= '0;
      sum_q      <= '0;
      im_we_q    <= 1'b0;
      im_addr_q  <= '0;
      im_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      n_q        <= n_d;
      loaded_q   <= loaded_d;
      sum_q      <= sum_d;
      im_we_q    <= im_we_d;
      im_addr_q  <= im_addr_d;
      im_wdata_q <= im_wdata_d;
    end
  end

  always_comb begin
    ready_int  = (state_q == S_HDR) || (state_q == S_LOAD) || (state_q == S_SUM);
    accept     = bl.byte_valid && ready_int;
    word       = {shift_q, bl.byte_data};
    word_done  = accept && (byte_cnt_q == 2'd3);

    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    n_d        = n_q;
    loaded_d   = loaded_q;
    sum_d      = sum_q;
    im_we_d    = 1'b0;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;

    // Earlier bytes shift toward the top, so byte 0 ends up in [31:24].
    if (accept) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      shift_d    = {shift_q[15:0], bl.byte_data};
    end

    case (state_q)
      S_HDR: begin
        if (word_done) begin
          if (word == 32'd0) begin
            n_d     = '0;
            state_d = S_SUM;
          end else if (word > MAX_WORDS) begin
            state_d = S_ERR;
          end else begin
            n_d     = word[ADDR_WIDTH:0];
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (word_done) begin
          im_we_d    = 1'b1;
          im_addr_d  = loaded_q[ADDR_WIDTH-1:0];
          im_wdata_d = word;
          loaded_d   = loaded_q + 1'b1;
          sum_d      = sum_q + word;
          if (loaded_d == n_q) begin
            state_d = S_SUM;
          end
        end
      end
      S_SUM: begin
        if (word_done) begin
          state_d = (word == sum_q) ? S_DONE : S_ERR;
        end
      end
      S_DONE, S_ERR: begin
        if (bl.reload) begin
          state_d    = S_HDR;
          byte_cnt_d = '0;
          shift_d    = '0;
          loaded_d   = '0;
          sum_d      = '0;
        end
      end
      default: state_d = S_HDR;
    endcase
  end

  // byte_ready stays low while reset is held so nothing is offered before the loader is live.
  assign bl.byte_ready   = ready_int && reset_n;
  assign bl.im_we        = im_we_q;
  assign bl.im_addr      = im_addr_q;
  assign bl.im_wdata     = im_wdata_q;
  assign bl.cpu_run      = (state_q == S_DONE);
  assign bl.load_err     = (state_q == S_ERR);
  assign bl.words_loaded = loaded_q;
  assign bl.dbg_state    = state_q;

endmodule
